mdio_engine: RTL and testbench
==============================

MDIO_ENGINE -- requirements
Module: mdio_engine

Interface
REQ-001 SHALL have parameter C_CLK_DIV, default 50: clk cycles per MDC half-period; legal values are 1 and above.
REQ-002 SHALL have parameter C_PREAMBLE_LEN, default 32: number of preamble '1' bits; legal values are 0 to 32.
REQ-003 SHALL use a single clock; reset is synchronous and active-high.
- clk  in  1  sole clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  transaction request
- req_ready  out  1  engine can accept a request
- req_op  in  2  01 = write, 10 = read, others invalid
- req_phy  in  5  PHY address
- req_reg  in  5  register address
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  16  read data
- rsp_err  out  1  invalid op, or read turnaround not driven low
- busy  out  1  frame in progress
- mdio_i  in  1  pad input from the IOBUF O pin
- mdio_o  out  1  pad output to the IOBUF I pin
- mdio_t  out  1  tristate control to the IOBUF T pin; 1 = released
- mdc  out  1  MDIO clock, registered

Function
REQ-004 SHALL accept a request in the cycle where req_valid and req_ready are both high; all req_* fields are captured in that cycle (T).
REQ-005 SHALL drive req_ready = 1 only in IDLE; it is 0 in every other state.
REQ-006 SHALL implement the states IDLE, PRE, HDR, TA, DATA and DONE, with transitions IDLE->PRE->HDR->TA->DATA->DONE->IDLE; PRE is skipped when C_PREAMBLE_LEN = 0.
REQ-007 SHALL send the frame MSB-first in this bit order: preamble 1s, ST = 01, OP, PHY[4:0], REG[4:0], TA (2 bits), DATA[15:0]; a frame is N = C_PREAMBLE_LEN + 32 bits long.
REQ-008 SHALL time each bit k (0-based) as follows:
- low phase: cycles T+1+2*C_CLK_DIV*k through T+C_CLK_DIV*(2k+1)
- high phase: the following C_CLK_DIV cycles
- mdc = 0 during the low phase and 1 during the high phase
- mdio_o and mdio_t change only on the first low-phase cycle of a bit
REQ-009 SHALL, on a write, drive mdio_t = 0 for all N bits, send TA as "10", and send req_wdata in the data field.
REQ-010 SHALL, on a read, drive mdio_t = 0 through REG[0], then drive mdio_t = 1 from the first TA bit until the end of the frame.
REQ-011 SHALL, on a read, register mdio_i on the last clk edge of each low phase (the edge where mdc rises).
- The sample taken in the second TA bit sets rsp_err if it is 1.
- The samples taken in the 16 data bits are shifted into rsp_rdata MSB-first.
REQ-012 SHALL enter DONE on the cycle after the last high phase, i.e. at T+2*C_CLK_DIV*N+1.
- In DONE: rsp_valid = 1 for exactly 1 cycle, mdc = 0, mdio_t = 1.
- After DONE: return to IDLE.
REQ-013 SHALL, on a write completion, set rsp_rdata = 0x0000 and rsp_err = 0.
REQ-014 SHALL hold rsp_rdata and rsp_err stable until the next rsp_valid.
REQ-015 SHALL handle an invalid op (00 or 11) as follows:
- no MDC edges, and mdio_t stays 1
- DONE is entered at T+1, with rsp_err = 1 and rsp_rdata = 0x0000
REQ-016 SHALL drive busy = 1 in every state except IDLE.
REQ-017 SHALL ignore req_valid and all req_* field changes outside the acceptance cycle.
REQ-018 SHALL, in IDLE, drive mdc = 0, mdio_o = 1 and mdio_t = 1.

Reset
REQ-019 SHALL, while rst = 1 and in the cycle after it, force the outputs to:
- state = IDLE
- mdc = 0, mdio_o = 1, mdio_t = 1
- rsp_valid = 0, rsp_rdata = 0x0000, rsp_err = 0
- busy = 0, req_ready = 0
REQ-020 SHALL drive req_ready = 1 from the first cycle after rst falls.
REQ-021 SHALL abort any frame when rst is asserted mid-frame; no rsp_valid is issued for the aborted transaction.

Verification (C_CLK_DIV = 2, C_PREAMBLE_LEN = 32 unless stated)
REQ-022 SHALL cover a write with op = 01, phy = 0x03, reg = 0x00, wdata = 0x1140.
- Required on mdio_o: 32 ones, then 01, 01, 00011, 00000, 10, 0001000101000000.
- Required: mdio_t = 0 throughout the frame, and rsp_valid at T+257 with rsp_err = 0.
REQ-023 SHALL cover a read with phy = 0x01, reg = 0x02, where the PHY model drives TA bit 2 = 0 and data 0x0141.
- Required: rsp_rdata = 0x0141, rsp_err = 0.
- Required: mdio_t = 1 from bit 46 onward.
REQ-024 SHALL cover a read with no PHY (mdio_i pulled to 1).
- Required: rsp_rdata = 0xFFFF, rsp_err = 1.
REQ-025 SHALL cover op = 11.
- Required: mdc stays 0, rsp_valid at T+1, rsp_err = 1.
REQ-026 SHALL cover rst pulsed for one cycle during bit 40 of a write.
- Required: next cycle mdc = 0, mdio_t = 1, and no rsp_valid.
- Required: a request issued after reset completes a full, correct frame.
REQ-027 SHALL cover C_PREAMBLE_LEN = 0 with req_valid held high continuously.
- Required: a 32-bit frame with rsp_valid at T+129.
- Required: the second request is accepted only at the first IDLE cycle after DONE.

Source files
------------

// File: rtl/mdio_engine.sv
// MDIO (Clause 22) management master: serialises one read or write frame per request
// on MDC/MDIO and returns a single-cycle completion with read data and error status.
module mdio_engine #(
  parameter int C_CLK_DIV      = 50,
  parameter int C_PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic        mdc
);

  localparam logic [6:0]  LAST_PRE  = 7'(C_PREAMBLE_LEN == 0 ? 0 : C_PREAMBLE_LEN - 1);
  localparam logic [6:0]  LAST_HDR  = 7'(C_PREAMBLE_LEN + 13);
  localparam logic [6:0]  LAST_TA   = 7'(C_PREAMBLE_LEN + 15);
  localparam logic [6:0]  LAST_DATA = 7'(C_PREAMBLE_LEN + 31);
  localparam logic [15:0] DIV_LAST  = 16'(C_CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] div_cnt;
  logic        phase_hi;
  logic [6:0]  bit_cnt;
  logic [31:0] sr;
  logic [31:0] hdr;
  logic        is_read;
  logic        mdc_q, mdio_o_q, mdio_t_q;
  logic [15:0] rd_sr, rdata_q;
  logic        err_q, ta_err;
  logic        accept, op_ok, in_frame, half_end, bit_end, sample;

  assign op_ok    = (req_op == 2'b01) || (req_op == 2'b10);
  assign accept   = (state == IDLE) && req_valid && !rst;
  assign in_frame = (state == PRE) || (state == HDR) || (state == TA) || (state == DATA);
  assign half_end = in_frame && (div_cnt == DIV_LAST);
  assign bit_end  = half_end && phase_hi;
  assign sample   = half_end && !phase_hi;

  // Everything after the preamble; a read releases the bus from TA on, so its TA/data are don't-care 1s.
  assign hdr = {2'b01, req_op, req_phy, req_reg,
                (req_op == 2'b01) ? 2'b10 : 2'b11,
                (req_op == 2'b01) ? req_wdata : 16'hFFFF};

  always_comb begin
    state_nxt = state;
    req_ready = (state == IDLE) && !rst;
    busy      = (state != IDLE) && !rst;
    rsp_valid = (state == DONE) && !rst;
    mdc       = mdc_q & ~rst;
    mdio_o    = mdio_o_q | rst;
    mdio_t    = mdio_t_q | rst;
    rsp_rdata = rst ? 16'h0000 : rdata_q;
    rsp_err   = err_q & ~rst;
    case (state)
      IDLE:    if (accept) state_nxt = !op_ok ? DONE : ((C_PREAMBLE_LEN == 0) ? HDR : PRE);
      PRE:     if (bit_end && bit_cnt == LAST_PRE)  state_nxt = HDR;
      HDR:     if (bit_end && bit_cnt == LAST_HDR)  state_nxt = TA;
      TA:      if (bit_end && bit_cnt == LAST_TA)   state_nxt = DATA;
      DATA:    if (bit_end && bit_cnt == LAST_DATA) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      phase_hi <= 1'b0;
      bit_cnt  <= '0;
      mdc_q    <= 1'b0;
      mdio_o_q <= 1'b1;
      mdio_t_q <= 1'b1;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        div_cnt  <= '0;
        phase_hi <= 1'b0;
        bit_cnt  <= '0;
        mdc_q    <= 1'b0;
        if (op_ok) begin
          mdio_t_q <= 1'b0;
          mdio_o_q <= (C_PREAMBLE_LEN == 0) ? hdr[31] : 1'b1;
        end else begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end else if (in_frame) begin
        if (half_end) begin
          div_cnt  <= '0;
          phase_hi <= !phase_hi;
          mdc_q    <= !phase_hi;
        end else begin
          div_cnt <= div_cnt + 16'd1;
        end
        // New bit values are launched only at the low-phase start of the next bit.
        if (bit_end) begin
          if (state_nxt == DONE) begin
            mdio_o_q <= 1'b1;
            mdio_t_q <= 1'b1;
            rdata_q  <= is_read ? rd_sr : 16'h0000;
            err_q    <= is_read & ta_err;
          end else begin
            bit_cnt  <= bit_cnt + 7'd1;
            mdio_o_q <= (state_nxt == PRE) ? 1'b1 : sr[31];
            mdio_t_q <= is_read && ((state_nxt == TA) || (state_nxt == DATA));
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      is_read <= (req_op == 2'b10);
      sr      <= (C_PREAMBLE_LEN == 0) ? {hdr[30:0], 1'b0} : hdr;
    end else if (bit_end && state_nxt != PRE && state_nxt != DONE) begin
      sr <= {sr[30:0], 1'b0};
    end
    // mdio_i is captured on the edge that raises MDC.
    if (sample && is_read) begin
      if (state == TA && bit_cnt == LAST_TA) ta_err <= mdio_i;
      if (state == DATA) rd_sr <= {rd_sr[14:0], mdio_i};
    end
  end

endmodule

// File: tb/tb_mdio_engine.sv
// Scoreboard bench for mdio_engine: two instances (32-bit and zero preamble), directed
// read/write/invalid/reset vectors, frame capture on MDC rises and a simple PHY model.
module tb_mdio_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [4:0]  req_phy = '0, req_reg = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid, rsp_err, busy, mdio_i, mdio_o, mdio_t, mdc;
  logic [15:0] rsp_rdata;

  logic        b_req_valid = 1'b0, b_req_ready;
  logic [1:0]  b_req_op = 2'b00;
  logic [4:0]  b_req_phy = '0, b_req_reg = '0;
  logic [15:0] b_req_wdata = '0;
  logic        b_rsp_valid, b_rsp_err, b_busy, b_mdio_o, b_mdio_t, b_mdc;
  logic        b_mdio_i = 1'b1;
  logic [15:0] b_rsp_rdata;

  mdio_engine #(.C_CLK_DIV(2), .C_PREAMBLE_LEN(32)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .mdio_i(mdio_i),
    .mdio_o(mdio_o), .mdio_t(mdio_t), .mdc(mdc));

  mdio_engine #(.C_CLK_DIV(2), .C_PREAMBLE_LEN(0)) u1 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
    .req_phy(b_req_phy), .req_reg(b_req_reg), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy), .mdio_i(b_mdio_i),
    .mdio_o(b_mdio_o), .mdio_t(b_mdio_t), .mdc(b_mdc));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          at;
  } exp_t;
  exp_t q0[$], q1[$];

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (q0.size() == 0) chk("u0 unexpected rsp_valid", 1, 0);
      else begin
        e = q0.pop_front();
        chk("u0 rsp_rdata", rsp_rdata, e.rdata);
        chk("u0 rsp_err", rsp_err, e.err);
        chk("u0 rsp cycle", cyc, e.at);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_rsp_valid) begin
      if (q1.size() == 0) chk("u1 unexpected rsp_valid", 1, 0);
      else begin
        e = q1.pop_front();
        chk("u1 rsp_rdata", b_rsp_rdata, e.rdata);
        chk("u1 rsp_err", b_rsp_err, e.err);
        chk("u1 rsp cycle", cyc, e.at);
      end
    end
  end

  // Frame capture on u0: bit k lands in cap_*[63-k] at each MDC rise.
  int          k = 0;
  logic        mdc_prev = 1'b0, t_low = 1'b0;
  logic [63:0] cap_o = '1, cap_t = '1;
  always @(negedge clk) begin
    if (req_valid && req_ready) begin
      k = 0; t_low = 1'b0; cap_o = '1; cap_t = '1;
    end else begin
      if (!mdio_t) t_low = 1'b1;
      if (mdc && !mdc_prev && k < 64) begin
        cap_o[63-k] = mdio_o;
        cap_t[63-k] = mdio_t;
        k = k + 1;
      end
    end
    mdc_prev = mdc;
  end

  // PHY model: TA bit 2 driven low, then data MSB-first; released (pulled up) otherwise.
  logic        phy_en = 1'b0;
  logic [15:0] phy_data = '0;
  assign mdio_i = !phy_en ? 1'b1 :
                  (k == 47) ? 1'b0 :
                  (k >= 48 && k < 64) ? phy_data[4'(63 - k)] : 1'b1;

  task automatic issue0(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rg,
                        input logic [15:0] wd, input logic push, input logic [15:0] er,
                        input logic ee, input int lat, output int t);
    exp_t e;
    bit   ok = 1'b0;
    t = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_phy = phy; req_reg = rg; req_wdata = wd;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("u0 accept timeout", 0, 1);
    t = cyc;
    if (push) begin
      e.rdata = er; e.err = ee; e.at = t + lat;
      q0.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = ~op; req_phy = ~phy; req_reg = ~rg; req_wdata = ~wd;
  endtask

  task automatic wait_done0();
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("u0 completion timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, t1, t2;
    exp_t e;
    bit ok;

    repeat (3) @(negedge clk);
    chk("reset req_ready", req_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset mdc", mdc, 0);
    chk("reset mdio_o", mdio_o, 1);
    chk("reset mdio_t", mdio_t, 1);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset rsp_err", rsp_err, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("req_ready after reset", req_ready, 1);
    chk("u1 req_ready after reset", b_req_ready, 1);

    // Write: phy 3, reg 0, data 0x1140
    issue0(2'b01, 5'h03, 5'h00, 16'h1140, 1'b1, 16'h0000, 1'b0, 257, t);
    wait_done0();
    chk("write mdio_o frame", cap_o, 64'hFFFFFFFF_51821140);
    chk("write mdio_t frame", cap_t, 64'h0);
    chk("write mdc rises", k, 64);

    // Read with PHY driving 0x0141
    phy_en = 1'b1; phy_data = 16'h0141;
    issue0(2'b10, 5'h01, 5'h02, 16'h0000, 1'b1, 16'h0141, 1'b0, 257, t);
    wait_done0();
    phy_en = 1'b0;
    chk("read mdio_o header", {18'h0, cap_o[63:18]}, {18'h0, 32'hFFFFFFFF, 14'b01100000100010});
    chk("read mdio_t frame", cap_t, 64'h0000_0000_0003_FFFF);
    repeat (5) @(negedge clk);
    chk("rsp_rdata held", rsp_rdata, 16'h0141);
    chk("rsp_err held", rsp_err, 0);

    // Read with no PHY present
    issue0(2'b10, 5'h1F, 5'h05, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 257, t);
    wait_done0();

    // Invalid op 11
    issue0(2'b11, 5'h01, 5'h01, 16'hBEEF, 1'b1, 16'h0000, 1'b1, 1, t);
    wait_done0();
    chk("invalid op mdc rises", k, 0);
    chk("invalid op mdio_t low seen", t_low, 0);

    // Reset pulse during bit 40 of a write
    issue0(2'b01, 5'h03, 5'h04, 16'h1234, 1'b0, 16'h0000, 1'b0, 0, t);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (cyc >= t + 162) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("bit 40 reach timeout", 0, 1);
    chk("bit index before reset", k, 40);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post-reset mdc", mdc, 0);
    chk("post-reset mdio_t", mdio_t, 1);
    chk("post-reset rsp_valid", rsp_valid, 0);
    chk("post-reset busy", busy, 0);
    chk("post-reset req_ready", req_ready, 1);
    repeat (300) @(negedge clk);

    issue0(2'b01, 5'h1F, 5'h1F, 16'hA5C3, 1'b1, 16'h0000, 1'b0, 257, t);
    wait_done0();
    chk("write after reset frame", cap_o, 64'hFFFFFFFF_5FFEA5C3);
    chk("write after reset mdio_t", cap_t, 64'h0);

    // Zero-preamble instance, req_valid held high across two requests
    @(posedge clk); #1;
    b_req_valid = 1'b1; b_req_op = 2'b01; b_req_phy = 5'h02; b_req_reg = 5'h03; b_req_wdata = 16'h1234;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (b_req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("u1 first accept timeout", 0, 1);
    t1 = cyc;
    e.rdata = 16'h0000; e.err = 1'b0; e.at = t1 + 129;
    q1.push_back(e);
    @(posedge clk); #1;
    b_req_op = 2'b10; b_req_phy = 5'h04; b_req_reg = 5'h05; b_req_wdata = 16'h0000;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (b_req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("u1 second accept timeout", 0, 1);
    t2 = cyc;
    chk("u1 second accept cycle", t2, t1 + 130);
    e.rdata = 16'hFFFF; e.err = 1'b1; e.at = t2 + 129;
    q1.push_back(e);
    @(posedge clk); #1 b_req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (q1.size() == 0 && !b_busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("u1 completion timeout", 0, 1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
